// File: rtl/fas_pkg.sv
// ============================================================================
// fas_pkg : shared types and widths for the frequency-analysis run sequencer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package fas_pkg;

  localparam int FAS_DATA_W = 16;
  localparam int FAS_FREQ_W = 4;
  localparam int FAS_IDX_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_FEED   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_REPORT = 3'd4
  } fas_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/fas_seq_ctrl_if.sv
// ============================================================================
// fas_seq_ctrl_if : command, sample, pipeline and result signals of the sequencer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface fas_seq_ctrl_if;
  import fas_pkg::*;

  logic                  start;
  logic [FAS_IDX_W-1:0]  num_frames;
  logic                  src_valid;
  logic [FAS_DATA_W-1:0] src_data;
  logic                  src_ready;
  logic                  pipe_rst;
  logic                  pipe_data_valid;
  logic [FAS_DATA_W-1:0] pipe_data;
  logic                  pipe_done;
  logic [FAS_FREQ_W-1:0] pipe_freq;
  logic                  res_valid;
  logic [FAS_FREQ_W-1:0] res_freq;
  logic [FAS_IDX_W-1:0]  res_idx;
  logic                  res_ready;
  logic                  busy;
  logic                  run_done;
  logic                  timeout_err;

  // master: the sequencer itself
  modport master (
    input  start, num_frames, src_valid, src_data, pipe_done, pipe_freq, res_ready,
    output src_ready, pipe_rst, pipe_data_valid, pipe_data, res_valid, res_freq,
           res_idx, busy, run_done, timeout_err
  );

  // slave: the surrounding source, pipeline and result consumer
  modport slave (
    output start, num_frames, src_valid, src_data, pipe_done, pipe_freq, res_ready,
    input  src_ready, pipe_rst, pipe_data_valid, pipe_data, res_valid, res_freq,
           res_idx, busy, run_done, timeout_err
  );

endinterface

`default_nettype wire

// File: rtl/fas_wdog.sv
// ============================================================================
// fas_wdog : clear/enable watchdog counter, expire flags the last allowed cycle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fas_wdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == 16'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/fas_seq_ctrl.sv
// ============================================================================
// fas_seq_ctrl : meters FRAME_LEN samples per frame into the pipeline, collects
//                one freq result per frame and watchdogs the pipeline wait
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fas_seq_ctrl
  import fas_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int TIMEOUT   = 1023
) (
  input  logic           clk,
  input  logic           rst,
  fas_seq_ctrl_if.master bus
);

  localparam int FEED_W = $clog2(FRAME_LEN + 1);

  fas_seq_state_t        state_q, state_d;
  logic [FEED_W-1:0]     feed_cnt_q, feed_cnt_d;
  logic [FAS_IDX_W-1:0]  frame_idx_q, frame_idx_d;
  logic [FAS_IDX_W-1:0]  num_q, num_d;
  logic                  pipe_rst_q, pipe_rst_d;
  logic                  pipe_data_valid_q, pipe_data_valid_d;
  logic [FAS_DATA_W-1:0] pipe_data_q, pipe_data_d;
  logic [FAS_FREQ_W-1:0] res_freq_q, res_freq_d;
  logic [FAS_IDX_W-1:0]  res_idx_q, res_idx_d;
  logic                  run_done_q, run_done_d;
  logic                  timeout_err_q, timeout_err_d;

  logic src_ready;
  logic accept;
  logic last_sample;
  logic wd_expire;

  assign src_ready   = (state_q == ST_FEED) && (feed_cnt_q < FEED_W'(FRAME_LEN));
  assign accept      = src_ready && bus.src_valid;
  assign last_sample = accept && (feed_cnt_q == FEED_W'(FRAME_LEN - 1));

  fas_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (last_sample),
    .enable (state_q == ST_WAIT),
    .expire (wd_expire)
  );

  always_comb begin
    state_d           = state_q;
    feed_cnt_d        = feed_cnt_q;
    frame_idx_d       = frame_idx_q;
    num_d             = num_q;
    pipe_rst_d        = 1'b1;
    pipe_data_valid_d = 1'b0;
    pipe_data_d       = pipe_data_q;
    res_freq_d        = res_freq_q;
    res_idx_d         = res_idx_q;
    run_done_d        = 1'b0;
    timeout_err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && (bus.num_frames != '0)) begin
          num_d       = bus.num_frames;
          frame_idx_d = '0;
          pipe_rst_d  = 1'b0;
          state_d     = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        feed_cnt_d = '0;
        state_d    = ST_FEED;
      end
      ST_FEED: begin
        if (accept) begin
          feed_cnt_d        = feed_cnt_q + FEED_W'(1);
          pipe_data_d       = bus.src_data;
          pipe_data_valid_d = 1'b1;
          if (last_sample) begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // a done arriving on the expiry cycle still delivers the result
        if (bus.pipe_done) begin
          res_freq_d = bus.pipe_freq;
          res_idx_d  = frame_idx_q;
          state_d    = ST_REPORT;
        end else if (wd_expire) begin
          timeout_err_d = 1'b1;
          pipe_rst_d    = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      ST_REPORT: begin
        if (bus.res_ready) begin
          if (frame_idx_q == num_q - 8'd1) begin
            run_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_idx_d = frame_idx_q + 8'd1;
            feed_cnt_d  = '0;
            state_d     = ST_FEED;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q           <= ST_IDLE;
      feed_cnt_q        <= '0;
      frame_idx_q       <= '0;
      num_q             <= '0;
      pipe_rst_q        <= 1'b0;
      pipe_data_valid_q <= 1'b0;
      pipe_data_q       <= '0;
      res_freq_q        <= '0;
      res_idx_q         <= '0;
      run_done_q        <= 1'b0;
      timeout_err_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      feed_cnt_q        <= feed_cnt_d;
      frame_idx_q       <= frame_idx_d;
      num_q             <= num_d;
      pipe_rst_q        <= pipe_rst_d;
      pipe_data_valid_q <= pipe_data_valid_d;
      pipe_data_q       <= pipe_data_d;
      res_freq_q        <= res_freq_d;
      res_idx_q         <= res_idx_d;
      run_done_q        <= run_done_d;
      timeout_err_q     <= timeout_err_d;
    end
  end

  assign bus.src_ready       = src_ready;
  assign bus.pipe_rst        = pipe_rst_q;
  assign bus.pipe_data_valid = pipe_data_valid_q;
  assign bus.pipe_data       = pipe_data_q;
  assign bus.res_valid       = (state_q == ST_REPORT);
  assign bus.res_freq        = res_freq_q;
  assign bus.res_idx         = res_idx_q;
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.run_done        = run_done_q;
  assign bus.timeout_err     = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_fas_seq_ctrl.sv
// ============================================================================
// tb_fas_seq_ctrl : scoreboard bench for the run sequencer (two watchdog sizes)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fas_seq_ctrl;
  import fas_pkg::*;

  localparam int TO_B = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  fas_seq_ctrl_if ifa ();
  fas_seq_ctrl_if ifb ();

  fas_seq_ctrl #(.FRAME_LEN(16), .TIMEOUT(1023)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
  fas_seq_ctrl #(.FRAME_LEN(16), .TIMEOUT(TO_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

  logic [15:0] samp_q[$];
  logic [11:0] res_q[$];   // {idx, freq}
  int fwd_a = 0, res_cnt_a = 0, b_res_cycles = 0;

  // pipeline model for instance A: done+freq LAT cycles after 16 samples
  int m_cnt = 0, m_wait = 0, m_frame = 0, lat = 40;
  logic [3:0] freq_base = 4'd0;
  int stray_cnt = 0, stray_seen = 0;
  bit real_done = 1'b0;
  logic [3:0] m_f;

  always @(posedge clk) begin
    #1;
    ifa.pipe_done = 1'b0;
    real_done     = 1'b0;
    if (!rst || !ifa.pipe_rst) begin
      m_cnt = 0; m_wait = 0; m_frame = 0; ifa.pipe_freq = '0;
    end else begin
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_f = freq_base + 4'(m_frame);
          ifa.pipe_done = 1'b1;
          ifa.pipe_freq = m_f;
          real_done     = 1'b1;
          res_q.push_back({8'(m_frame), m_f});
          m_frame++;
        end
      end else if (stray_cnt != stray_seen) begin
        stray_seen    = stray_cnt;
        ifa.pipe_done = 1'b1;
        ifa.pipe_freq = 4'hF;
      end
      if (ifa.pipe_data_valid) begin
        m_cnt++;
        if (m_cnt == 16) begin m_cnt = 0; m_wait = lat; end
      end
    end
  end

  bit prev_real = 1'b0;
  logic [15:0] exp_s;
  logic [11:0] exp_r;

  always @(negedge clk) begin
    if (prev_real) begin
      n_tests++;
      if (ifa.res_valid !== 1'b1) begin
        n_fail++; $display("FAIL res_latency: res_valid=%b required 1", ifa.res_valid);
      end
    end
    prev_real = real_done;
    if (ifa.pipe_data_valid) begin
      fwd_a++; n_tests++;
      if (samp_q.size() == 0) begin
        n_fail++; $display("FAIL extra_sample: got %h, none expected", ifa.pipe_data);
      end else begin
        exp_s = samp_q.pop_front();
        if (ifa.pipe_data !== exp_s) begin
          n_fail++; $display("FAIL pipe_data: got %h, expected %h", ifa.pipe_data, exp_s);
        end
      end
    end
    if (rst && ifa.src_valid && ifa.src_ready) samp_q.push_back(ifa.src_data);
    if (ifa.res_valid) begin
      n_tests++;
      if (ifa.src_ready !== 1'b0) begin
        n_fail++; $display("FAIL ready_in_report: src_ready=%b required 0", ifa.src_ready);
      end
    end
    if (ifa.res_valid && ifa.res_ready) begin
      res_cnt_a++; n_tests++;
      if (res_q.size() == 0) begin
        n_fail++; $display("FAIL extra_result: got %h, none expected", {ifa.res_idx, ifa.res_freq});
      end else begin
        exp_r = res_q.pop_front();
        if ({ifa.res_idx, ifa.res_freq} !== exp_r) begin
          n_fail++; $display("FAIL result: got idx/freq %h, expected %h", {ifa.res_idx, ifa.res_freq}, exp_r);
        end
      end
    end
    if (ifb.res_valid) b_res_cycles++;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: sim time %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_a(input int n);
    ifa.start = 1'b1; ifa.num_frames = 8'(n);
    step();
    ifa.start = 1'b0;
  endtask

  task automatic feed_a(input int n, input bit toggle, input int base);
    int acc = 0, g = 0;
    bit take;
    while (acc < n && g < 400) begin
      ifa.src_valid = toggle ? (g % 2 == 0) : 1'b1;
      ifa.src_data  = (base >= 0) ? 16'(base + acc) : 16'($urandom);
      take = ifa.src_valid && ifa.src_ready;
      step();
      if (take) acc++;
      g++;
    end
    ifa.src_valid = 1'b0;
    n_tests++;
    if (acc != n) begin n_fail++; $display("FAIL feed_a: accepted %0d, required %0d", acc, n); end
  endtask

  task automatic finish_frame_a(input int dly, input bit last);
    int g = 0;
    while (!ifa.res_valid && g < 300) begin step(); g++; end
    n_tests++;
    if (ifa.res_valid !== 1'b1) begin n_fail++; $display("FAIL res_wait: res_valid=%b required 1", ifa.res_valid); end
    repeat (dly) step();
    ifa.res_ready = 1'b1;
    step();
    ifa.res_ready = 1'b0;
    n_tests++;
    if ({ifa.run_done, ifa.busy, ifa.src_ready} !== (last ? 3'b100 : 3'b011)) begin
      n_fail++; $display("FAIL after_handshake: run_done/busy/src_ready=%b required %b",
                         {ifa.run_done, ifa.busy, ifa.src_ready}, (last ? 3'b100 : 3'b011));
    end
    if (last) begin
      step();
      n_tests++;
      if (ifa.run_done !== 1'b0) begin n_fail++; $display("FAIL run_done_width: run_done=%b required 0", ifa.run_done); end
    end
  endtask

  task automatic feed_b(input int n);
    int acc = 0, g = 0;
    bit take;
    while (acc < n && g < 60) begin
      ifb.src_valid = 1'b1;
      ifb.src_data  = 16'(16'h100 + acc);
      take = ifb.src_ready;
      step();
      if (take) acc++;
      g++;
    end
    ifb.src_valid = 1'b0;
    n_tests++;
    if (acc != n) begin n_fail++; $display("FAIL feed_b: accepted %0d, required %0d", acc, n); end
  endtask

  task automatic check_deltas(input string nm, input int f0, input int r0, input int nf, input int nr);
    n_tests++;
    if ((fwd_a - f0) != nf || (res_cnt_a - r0) != nr) begin
      n_fail++; $display("FAIL %s: samples %0d results %0d, required %0d and %0d", nm, fwd_a - f0, res_cnt_a - r0, nf, nr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ifa.start = 1'b1; ifa.num_frames = 8'd3;
    repeat (3) step();
    n_tests++;
    if ({ifa.src_ready, ifa.pipe_data_valid, ifa.res_valid, ifa.busy, ifa.run_done, ifa.timeout_err, ifa.pipe_rst,
         ifb.busy, ifb.pipe_rst} !== 9'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 0", {ifa.src_ready, ifa.pipe_data_valid, ifa.res_valid,
                         ifa.busy, ifa.run_done, ifa.timeout_err, ifa.pipe_rst, ifb.busy, ifb.pipe_rst});
    end
    n_tests++;
    if ({ifa.pipe_data, ifa.res_freq, ifa.res_idx} !== 28'b0) begin
      n_fail++; $display("FAIL reset_data: got %h, required 0", {ifa.pipe_data, ifa.res_freq, ifa.res_idx});
    end
    ifa.start = 1'b0;
    rst = 1'b1;
    step();
    n_tests++;
    if ({ifa.pipe_rst, ifa.busy} !== 2'b10) begin
      n_fail++; $display("FAIL reset_release: pipe_rst/busy=%b required 10", {ifa.pipe_rst, ifa.busy});
    end
  endtask

  task automatic test_single_frame();
    int f0 = fwd_a, r0 = res_cnt_a;
    lat = 40; freq_base = 4'd5;
    start_a(1);
    n_tests++;
    if ({ifa.busy, ifa.pipe_rst, ifa.src_ready} !== 3'b100) begin
      n_fail++; $display("FAIL start_cycle1: busy/pipe_rst/src_ready=%b required 100", {ifa.busy, ifa.pipe_rst, ifa.src_ready});
    end
    step();
    n_tests++;
    if ({ifa.src_ready, ifa.pipe_rst} !== 2'b11) begin
      n_fail++; $display("FAIL start_cycle2: src_ready/pipe_rst=%b required 11", {ifa.src_ready, ifa.pipe_rst});
    end
    feed_a(16, 1'b0, 1);
    finish_frame_a(0, 1'b1);
    check_deltas("single_counts", f0, r0, 16, 1);
  endtask

  task automatic test_multi_frame();
    int f0 = fwd_a, r0 = res_cnt_a;
    lat = 10; freq_base = 4'd9;
    start_a(3);
    for (int f = 0; f < 3; f++) begin
      feed_a(16, 1'b1, -1);
      finish_frame_a(7, f == 2);
    end
    check_deltas("multi_counts", f0, r0, 48, 3);
  endtask

  task automatic test_ignored();
    int f0, r0;
    ifa.start = 1'b1; ifa.num_frames = 8'd0;
    step();
    ifa.start = 1'b0;
    n_tests++;
    if ({ifa.busy, ifa.pipe_rst} !== 2'b01) begin
      n_fail++; $display("FAIL zero_frames: busy/pipe_rst=%b required 01", {ifa.busy, ifa.pipe_rst});
    end
    f0 = fwd_a; r0 = res_cnt_a;
    lat = 12; freq_base = 4'd2;
    start_a(1);
    feed_a(5, 1'b0, -1);
    ifa.start = 1'b1; ifa.num_frames = 8'd5; stray_cnt++;
    step();
    ifa.start = 1'b0;
    n_tests++;
    if ({ifa.busy, ifa.src_ready} !== 2'b11) begin
      n_fail++; $display("FAIL start_while_busy: busy/src_ready=%b required 11", {ifa.busy, ifa.src_ready});
    end
    feed_a(11, 1'b0, -1);
    finish_frame_a(0, 1'b1);
    check_deltas("ignored_counts", f0, r0, 16, 1);
  endtask

  task automatic test_reset_mid_feed();
    int f0, r0;
    lat = 15; freq_base = 4'd7;
    start_a(2);
    feed_a(9, 1'b0, -1);
    rst = 1'b0;
    step(); step();
    n_tests++;
    if ({ifa.src_ready, ifa.pipe_data_valid, ifa.res_valid, ifa.busy, ifa.run_done, ifa.timeout_err, ifa.pipe_rst} !== 7'b0) begin
      n_fail++; $display("FAIL midrun_reset_flags: got %b, required 0", {ifa.src_ready, ifa.pipe_data_valid,
                         ifa.res_valid, ifa.busy, ifa.run_done, ifa.timeout_err, ifa.pipe_rst});
    end
    n_tests++;
    if ({ifa.pipe_data, ifa.res_freq, ifa.res_idx} !== 28'b0) begin
      n_fail++; $display("FAIL midrun_reset_data: got %h, required 0", {ifa.pipe_data, ifa.res_freq, ifa.res_idx});
    end
    rst = 1'b1;
    step();
    n_tests++;
    if ({ifa.pipe_rst, ifa.busy, ifa.run_done, ifa.timeout_err} !== 4'b1000) begin
      n_fail++; $display("FAIL midrun_release: got %b, required 1000", {ifa.pipe_rst, ifa.busy, ifa.run_done, ifa.timeout_err});
    end
    f0 = fwd_a; r0 = res_cnt_a;
    start_a(1);
    feed_a(16, 1'b0, -1);
    finish_frame_a(0, 1'b1);
    check_deltas("rerun_counts", f0, r0, 16, 1);
  endtask

  task automatic test_timeout();
    int t_last, g = 0, b0;
    ifb.num_frames = 8'd1; ifb.start = 1'b1;
    step();
    ifb.start = 1'b0;
    feed_b(16);
    t_last = cyc;
    b0 = b_res_cycles;
    while (!ifb.timeout_err && g < 60) begin step(); g++; end
    n_tests++;
    if (ifb.timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_missing: timeout_err=%b required 1", ifb.timeout_err); end
    n_tests++;
    if (cyc - t_last != TO_B) begin n_fail++; $display("FAIL timeout_delay: %0d cycles, required %0d", cyc - t_last, TO_B); end
    n_tests++;
    if ({ifb.pipe_rst, ifb.busy, ifb.res_valid} !== 3'b000) begin
      n_fail++; $display("FAIL timeout_state: pipe_rst/busy/res_valid=%b required 000", {ifb.pipe_rst, ifb.busy, ifb.res_valid});
    end
    step();
    n_tests++;
    if ({ifb.timeout_err, ifb.pipe_rst} !== 2'b01) begin
      n_fail++; $display("FAIL timeout_pulse: timeout_err/pipe_rst=%b required 01", {ifb.timeout_err, ifb.pipe_rst});
    end
    n_tests++;
    if (b_res_cycles != b0) begin n_fail++; $display("FAIL timeout_result: res_valid cycles %0d, required 0", b_res_cycles - b0); end
  endtask

  task automatic test_done_at_expiry();
    ifb.num_frames = 8'd1; ifb.start = 1'b1;
    step();
    ifb.start = 1'b0;
    feed_b(16);
    repeat (TO_B - 1) step();
    ifb.pipe_done = 1'b1; ifb.pipe_freq = 4'hB;
    step();
    ifb.pipe_done = 1'b0; ifb.pipe_freq = 4'h0;
    n_tests++;
    if ({ifb.timeout_err, ifb.res_valid} !== 2'b01) begin
      n_fail++; $display("FAIL done_vs_expiry: timeout_err/res_valid=%b required 01", {ifb.timeout_err, ifb.res_valid});
    end
    n_tests++;
    if ({ifb.res_freq, ifb.res_idx} !== {4'hB, 8'd0}) begin
      n_fail++; $display("FAIL expiry_result: got %h, required %h", {ifb.res_freq, ifb.res_idx}, {4'hB, 8'd0});
    end
    ifb.res_ready = 1'b1;
    step();
    ifb.res_ready = 1'b0;
    n_tests++;
    if ({ifb.run_done, ifb.busy, ifb.timeout_err} !== 3'b100) begin
      n_fail++; $display("FAIL expiry_run_done: run_done/busy/timeout_err=%b required 100", {ifb.run_done, ifb.busy, ifb.timeout_err});
    end
  endtask

  initial begin
    ifa.start = 1'b0; ifa.num_frames = '0; ifa.src_valid = 1'b0; ifa.src_data = '0; ifa.res_ready = 1'b0;
    ifb.start = 1'b0; ifb.num_frames = '0; ifb.src_valid = 1'b0; ifb.src_data = '0; ifb.res_ready = 1'b0;
    ifb.pipe_done = 1'b0; ifb.pipe_freq = '0;

    test_reset();
    test_single_frame();
    test_multi_frame();
    test_ignored();
    test_reset_mid_feed();
    test_timeout();
    test_done_at_expiry();

    repeat (3) step();
    n_tests++;
    if (samp_q.size() != 0 || res_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d samples %0d results left, required 0", samp_q.size(), res_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
